// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Holds the PC and reads instruction memory combinationally. It registers the
// fetched word for the decoder and honours stalls and branch/jump redirects.
// Fetching a HALT word freezes the PC until a redirect or reset arrives.
module if_fetch_unit #(
  parameter int unsigned          PC_W     = 16,
  parameter logic [PC_W-1:0]      RESET_PC = '0,
  parameter logic [15:0]          HALT_IW  = 16'hFFFF,
  parameter logic [15:0]          NOP_IW   = 16'hF000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     IW,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus1,
  output logic            v,
  output logic            halted
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     iw_q, iw_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic [PC_W-1:0] pc_plus1_q, pc_plus1_d;
  logic            v_q, v_d;

  // Next-state logic: redirect outranks stall; stall freezes everything in RUN.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iw_d       = iw_q;
    pc_out_d   = pc_out_q;
    pc_plus1_d = pc_plus1_q;
    v_d        = v_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      iw_d    = NOP_IW;
      v_d     = 1'b0;
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (!stall) begin
            iw_d       = imem_data;
            pc_out_d   = pc_q;
            pc_plus1_d = pc_q + PC_ONE;
            v_d        = 1'b1;
            if (imem_data == HALT_IW) begin
              state_d = S_HALT;
            end else begin
              pc_d = pc_q + PC_ONE;
            end
          end
        end
        S_HALT: begin
          // Once the HALT word has been consumed, feed bubbles; a stall keeps it in IW.
          if (!stall) begin
            iw_d = NOP_IW;
            v_d  = 1'b0;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // State and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      iw_q       <= NOP_IW;
      pc_out_q   <= '0;
      pc_plus1_q <= '0;
      v_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iw_q       <= iw_d;
      pc_out_q   <= pc_out_d;
      pc_plus1_q <= pc_plus1_d;
      v_q        <= v_d;
    end
  end

  assign imem_addr = pc_q;
  assign IW        = iw_q;
  assign pc_out    = pc_out_q;
  assign pc_plus1  = pc_plus1_q;
  assign v         = v_q;
  assign halted    = (state_q == S_HALT);

endmodule
